// File: rtl/gate_sweep_checker.sv
// Self-test sequencer for the two-input gate bank: sweeps {a,b} through 00..11,
// waits a settle interval per vector, then checks all seven gate outputs against
// internally computed golden values. Results hold until the next accepted start.
module gate_sweep_checker #(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       start_i,
    output logic       a_drv_o,
    output logic       b_drv_o,
    input  logic [6:0] gate_in_i,
    output logic       busy_o,
    output logic       done_o,
    output logic       pass_o,
    output logic [6:0] err_mask_o,
    output logic [3:0] fail_vec_o
);

    // A settle interval of zero is treated as one cycle.
    localparam int unsigned SettleEff = (SETTLE_CYCLES == 0) ? 1 : SETTLE_CYCLES;
    localparam int unsigned CntW      = (SettleEff > 1) ? $clog2(SettleEff) : 1;
    // Counter runs from SettleEff-1 down to 0, one SETTLE cycle per count.
    localparam logic [CntW-1:0] CntLoad = CntW'(SettleEff - 1);

    typedef enum logic [1:0] {
        StIdle,
        StSettle,
        StSample,
        StDone
    } state_e;

    state_e          state_q, state_d;
    logic [1:0]      vec_q, vec_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            a_q, a_d;
    logic            b_q, b_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            pass_q, pass_d;
    logic [6:0]      mask_q, mask_d;
    logic [3:0]      fv_q, fv_d;

    logic            a_cur, b_cur;
    logic [6:0]      golden;
    logic [6:0]      mism;

    assign a_cur = vec_q[1];
    assign b_cur = vec_q[0];

    // Golden gate outputs for the vector currently driven, in gate_in bit order.
    assign golden = {~(a_cur ^ b_cur), a_cur ^ b_cur, ~(a_cur | b_cur), ~(a_cur & b_cur),
                     ~a_cur, a_cur | b_cur, a_cur & b_cur};
    assign mism   = gate_in_i ^ golden;

    // Next-state logic; registered outputs are derived from the next state so
    // they line up with the state they describe.
    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        cnt_d   = cnt_q;
        pass_d  = pass_q;
        mask_d  = mask_q;
        fv_d    = fv_q;

        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    state_d = StSettle;
                    vec_d   = 2'd0;
                    cnt_d   = CntLoad;
                    mask_d  = '0;
                    fv_d    = '0;
                    pass_d  = 1'b0;
                end
            end
            StSettle: begin
                if (cnt_q == '0) begin
                    state_d = StSample;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StSample: begin
                mask_d       = mask_q | mism;
                fv_d[vec_q]  = |mism;
                if (vec_q == 2'd3) begin
                    state_d = StDone;
                    // Uses the mask including this last vector's mismatches.
                    pass_d  = (mask_d == '0);
                end else begin
                    state_d = StSettle;
                    vec_d   = vec_q + 2'd1;
                    cnt_d   = CntLoad;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        busy_d = (state_d == StSettle) || (state_d == StSample);
        done_d = (state_d == StDone);
        a_d    = busy_d ? vec_d[1] : 1'b0;
        b_d    = busy_d ? vec_d[0] : 1'b0;
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            vec_q   <= 2'd0;
            cnt_q   <= '0;
            a_q     <= 1'b0;
            b_q     <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            mask_q  <= '0;
            fv_q    <= '0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            mask_q  <= mask_d;
            fv_q    <= fv_d;
        end
    end

    assign a_drv_o    = a_q;
    assign b_drv_o    = b_q;
    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign pass_o     = pass_q;
    assign err_mask_o = mask_q;
    assign fail_vec_o = fv_q;

endmodule

// File: tb/tb_gate_sweep_checker.sv
// Bench for gate_sweep_checker: a behavioural gate bank with selectable faults,
// a timeline model of the sweep checked every cycle, and directed literal checks.
module tb_gate_sweep_checker;

    localparam int S = 2;
    localparam int P = S + 1;       // cycles per vector
    localparam int L = 4 * P;       // busy cycles per run

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       start_s = 1'b0;
    logic       a_drv, b_drv, busy, done, pass;
    logic [6:0] gate_in, err_mask;
    logic [3:0] fail_vec;

    logic       a0, b0, busy0, done0, pass0;
    logic [6:0] gi0, em0;
    logic [3:0] fv0;
    logic       a1, b1, busy1, done1, pass1;
    logic [6:0] gi1, em1;
    logic [3:0] fv1;

    int         fault = 0;
    logic [6:0] flip [4];
    int         tests = 0;
    int         fails = 0;
    int         cyc = 0;
    bit         chk_en = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    gate_sweep_checker #(.SETTLE_CYCLES(S)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .a_drv_o(a_drv), .b_drv_o(b_drv),
        .gate_in_i(gate_in), .busy_o(busy), .done_o(done), .pass_o(pass),
        .err_mask_o(err_mask), .fail_vec_o(fail_vec)
    );
    gate_sweep_checker #(.SETTLE_CYCLES(0)) dut_s0 (
        .clk_i(clk), .rst_i(rst), .start_i(start_s), .a_drv_o(a0), .b_drv_o(b0),
        .gate_in_i(gi0), .busy_o(busy0), .done_o(done0), .pass_o(pass0),
        .err_mask_o(em0), .fail_vec_o(fv0)
    );
    gate_sweep_checker #(.SETTLE_CYCLES(1)) dut_s1 (
        .clk_i(clk), .rst_i(rst), .start_i(start_s), .a_drv_o(a1), .b_drv_o(b1),
        .gate_in_i(gi1), .busy_o(busy1), .done_o(done1), .pass_o(pass1),
        .err_mask_o(em1), .fail_vec_o(fv1)
    );

    function automatic logic [6:0] golden_of(logic a, logic b);
        return {~(a ^ b), a ^ b, ~(a | b), ~(a & b), ~a, a | b, a & b};
    endfunction

    // Gate bank with an optional planted fault.
    function automatic logic [6:0] bank_of(logic a, logic b, int mode);
        logic [6:0] g;
        g = golden_of(a, b);
        case (mode)
            1: g[5] = 1'b0;
            2: g[2] = a;
            3: g = g ^ flip[{a, b}];
            default: ;
        endcase
        return g;
    endfunction

    always_comb gate_in = bank_of(a_drv, b_drv, fault);
    always_comb gi0 = golden_of(a0, b0);
    always_comb gi1 = golden_of(a1, b1);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Timeline model: m_t counts cycles since the accepting edge (1 = first SETTLE).
    bit         m_run = 1'b0;
    int         m_t = 0;
    logic       m_pass = 1'b0;
    logic [6:0] m_mask = '0;
    logic [3:0] m_fv = '0;

    always @(posedge clk) begin
        int v;
        logic [6:0] mism;
        if (rst) begin
            m_run = 1'b0; m_t = 0; m_pass = 1'b0; m_mask = '0; m_fv = '0;
        end else if (!m_run) begin
            if (start) begin
                m_run = 1'b1; m_t = 1; m_pass = 1'b0; m_mask = '0; m_fv = '0;
            end
        end else begin
            if (m_t <= L && (m_t % P) == 0) begin
                v = m_t / P - 1;
                mism = bank_of(v[1], v[0], fault) ^ golden_of(v[1], v[0]);
                m_mask = m_mask | mism;
                m_fv[v] = |mism;
            end
            m_t++;
            if (m_t == L + 1) m_pass = (m_mask == '0);
            else if (m_t == L + 2) m_run = 1'b0;
        end
    end

    // Per-cycle comparison against the model, sampled on the falling edge.
    always @(negedge clk) begin
        logic e_busy, e_done, e_a, e_b;
        int v;
        if (chk_en) begin
            e_busy = m_run && m_t >= 1 && m_t <= L;
            e_done = m_run && m_t == L + 1;
            v = e_busy ? (m_t - 1) / P : 0;
            e_a = e_busy ? v[1] : 1'b0;
            e_b = e_busy ? v[0] : 1'b0;
            chk("cycle", {17'd0, a_drv, b_drv, busy, done, pass, err_mask, fail_vec},
                {17'd0, e_a, e_b, e_busy, e_done, m_pass, m_mask, m_fv});
        end
    end

    // One start pulse from IDLE; returns accept-to-done latency or -1 on timeout.
    task automatic run_one(output int lat);
        int acc;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        acc = cyc;
        lat = -1;
        for (int i = 0; i < 40; i++) begin
            if (done) begin
                lat = cyc - acc;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic check_result(input string name, input int lat, input logic ep,
                                input logic [6:0] em, input logic [3:0] ef);
        chk({name, "_lat"}, lat, 12);
        chk({name, "_pass"}, {31'd0, pass}, {31'd0, ep});
        chk({name, "_mask"}, {25'd0, err_mask}, {25'd0, em});
        chk({name, "_fvec"}, {28'd0, fail_vec}, {28'd0, ef});
    endtask

    initial begin
        int lat, d_prev, n_done, lat0, lat1;
        bit seen;
        for (int i = 0; i < 4; i++) flip[i] = '0;

        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        chk("reset_outputs", {17'd0, a_drv, b_drv, busy, done, pass, err_mask, fail_vec}, 0);
        rst = 1'b0;
        @(negedge clk);

        fault = 0; run_one(lat); check_result("healthy", lat, 1'b1, 7'b0000000, 4'b0000);
        fault = 1; run_one(lat); check_result("xor_stuck0", lat, 1'b0, 7'b0100000, 4'b0110);
        fault = 2; run_one(lat); check_result("not_is_a", lat, 1'b0, 7'b0000100, 4'b1111);
        fault = 0;

        // Held start: runs repeat every 14 cycles.
        @(negedge clk) start = 1'b1;
        d_prev = -1; n_done = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (done) begin
                if (d_prev >= 0) chk("held_period", cyc - d_prev, 14);
                d_prev = cyc;
                n_done++;
            end
        end
        chk("held_done_count", n_done >= 3, 1);
        start = 1'b0;
        repeat (16) @(negedge clk);

        // Reset while vector 2 is settling.
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;        // cycle t=1
        repeat (6) @(negedge clk);          // cycle t=7: vec 2, first SETTLE cycle
        chk("vec2_drive", {30'd0, a_drv, b_drv}, 32'd2);
        rst = 1'b1;
        @(negedge clk) rst = 1'b0;
        chk("rst_mid_run", {17'd0, a_drv, b_drv, busy, done, pass, err_mask, fail_vec}, 0);
        seen = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        chk("no_done_after_rst", seen, 0);
        run_one(lat); check_result("after_rst", lat, 1'b1, 7'b0000000, 4'b0000);

        // Randomised runs with random fault tables, start and occasional reset.
        fault = 3;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (!m_run && !start) begin
                for (int j = 0; j < 4; j++)
                    flip[j] = ($urandom_range(0, 2) == 0) ? 7'($urandom) : 7'd0;
            end
            start = ($urandom_range(0, 3) == 0);
            rst = ($urandom_range(0, 80) == 0);
        end
        start = 1'b0; rst = 1'b0; fault = 0;
        repeat (16) @(negedge clk);

        // SETTLE_CYCLES of 0 and 1 both give an 8-cycle run.
        @(negedge clk) start_s = 1'b1;
        @(negedge clk) start_s = 1'b0;
        lat = cyc; lat0 = -1; lat1 = -1;
        for (int i = 0; i < 30; i++) begin
            if (done0 && lat0 < 0) lat0 = cyc - lat;
            if (done1 && lat1 < 0) lat1 = cyc - lat;
            @(negedge clk);
        end
        chk("s0_lat", lat0, 8);
        chk("s1_lat", lat1, 8);
        chk("s0_pass", {31'd0, pass0}, 1);
        chk("s1_pass", {31'd0, pass1}, 1);

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/gate_sweep_checker.md
# gate_sweep_checker

Self-test sequencer that sits directly upstream of the two-input gate bank, driving its `a`/`b` inputs and consuming its seven gate outputs. On a start request it sweeps `{a,b}` through 00, 01, 10, 11. For each vector it waits a settle interval, then compares all seven gate outputs against golden values computed internally. It reports pass/fail, a per-gate error mask and a per-vector failure vector, and is used for power-on and on-demand checking of the gate bank.

## Interface
Parameters:
- `SETTLE_CYCLES`, default 2: cycles `{a,b}` is held before sampling. Minimum 1; a value of 0 behaves as 1.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `start`  in  1  run request; sampled only in IDLE.
- `a_drv`  out  1  drives gate bank input A.
- `b_drv`  out  1  drives gate bank input B.
- `gate_in`  in  7  gate bank outputs. Bit order: [0] and, [1] or, [2] not (of A), [3] nand, [4] nor, [5] xor, [6] xnor.
- `busy`  out  1  high in SETTLE and SAMPLE.
- `done`  out  1  one-cycle pulse at end of run.
- `pass`  out  1  1 when the last completed run had no mismatches.
- `err_mask`  out  7  per-gate sticky mismatch flags, same bit order as `gate_in`.
- `fail_vec`  out  4  bit n set if vector n (n = {a,b}) had any mismatch.

## Operation
- All outputs are registered.
- Reset value of every output is 0. The FSM resets to IDLE and the vector index `vec` (2 bits) resets to 0.
- States: IDLE, SETTLE, SAMPLE, DONE.
- **IDLE**
  - `a_drv` = `b_drv` = 0.
  - `start`=1: clear `err_mask`, `fail_vec` and `pass`; set `vec`=0; load the settle counter; go to SETTLE.
- **SETTLE**
  - `a_drv` = `vec[1]`, `b_drv` = `vec[0]`.
  - Counts `SETTLE_CYCLES` cycles, then goes to SAMPLE.
- **SAMPLE**
  - Drive is unchanged.
  - Golden values: and=a&b, or=a|b, not=~a, nand=~(a&b), nor=~(a|b), xor=a^b, xnor=~(a^b).
  - `mism` = `gate_in` XOR golden.
  - `err_mask` |= `mism`; `fail_vec[vec]` = OR-reduce(`mism`).
  - If `vec`==3, go to DONE. Otherwise `vec`++ and go to SETTLE.
- **DONE**
  - `a_drv` = `b_drv` = 0, `done`=1.
  - `pass` = (`err_mask`==0), using the final updated mask.
  - Next state: IDLE.
- `pass`, `err_mask` and `fail_vec` hold their values until the next accepted start or reset.
- `start` is ignored in SETTLE, SAMPLE and DONE. There is no queuing; a start held high is accepted again on the first IDLE cycle.
- `vec` does not wrap. The run terminates after vector 3.

## Timing
- Start accepted at edge k: SETTLE begins in the cycle after edge k.
- Each vector occupies `SETTLE_CYCLES`+1 cycles: `SETTLE_CYCLES` in SETTLE plus 1 in SAMPLE.
- `gate_in` is compared at the edge that ends the SAMPLE cycle. The gate bank therefore gets at least `SETTLE_CYCLES`+1 cycles of stable input.
- `done` is high in the cycle after edge k+4·(`SETTLE_CYCLES`+1). With the default, that is 12 cycles after the accepting edge.
- IDLE resumes one cycle later. Back-to-back runs are spaced 4·(`SETTLE_CYCLES`+1)+2 cycles apart.
- `busy` rises the cycle after the accepting edge and falls in the DONE cycle.
- **Reset mid-run:** at the next edge every output is 0 and the FSM is in IDLE. No `done` pulse; partial results are discarded.
- **Start and reset asserted together:** reset wins.

## Test plan
- **Healthy gate bank connected, `SETTLE_CYCLES`=2, 1-cycle start pulse:**
  - `{a_drv,b_drv}` = 00,01,10,11, each held 3 cycles.
  - `done` pulses 12 cycles after the accepting edge.
  - `pass`=1, `err_mask`=0000000, `fail_vec`=0000.
- **`gate_in[5]` (xor) stuck at 0:**
  - `pass`=0, `err_mask`=0100000, `fail_vec`=0110.
- **`gate_in[2]` driven as `a` instead of `~a`:**
  - `err_mask`=0000100, `fail_vec`=1111, `pass`=0.
- **`start` held high continuously:**
  - Runs repeat; `done` pulses every 14 cycles.
  - `start` has no effect while `busy`=1.
- **`rst` asserted for 1 cycle while `vec`=2 in SETTLE:**
  - Next cycle: `busy`=0, `a_drv`=`b_drv`=0, `pass`=0, `err_mask`=0, `fail_vec`=0.
  - No `done` pulse.
  - A new start completes normally.
- **`SETTLE_CYCLES`=0 and `SETTLE_CYCLES`=1, healthy bank:**
  - Both give `done` 8 cycles after the accepting edge, `pass`=1.
